// File: rtl/cast5_round_ctrl.sv
// Iterative CAST5 round sequencer: holds the L/R halves, steps 12 or 16 rounds over
// a shared F datapath via a req/ack handshake, and hands the swapped result out.
module cast5_round_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        ready,
    input  logic        decrypt,
    input  logic        short_key,
    input  logic [63:0] din,
    output logic [3:0]  rnd_idx,
    input  logic [31:0] km,
    input  logic [4:0]  kr,
    output logic        f_req,
    input  logic        f_ack,
    output logic [31:0] f_din,
    output logic [31:0] f_km,
    output logic [4:0]  f_rot,
    output logic [1:0]  f_type,
    input  logic [31:0] f_dout,
    output logic [63:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_l;
    logic [31:0] r_r;
    logic [3:0]  r_k;
    logic        r_decrypt;
    logic        r_short;
    logic [3:0]  w_last_idx;
    logic        w_last;

    // N-1 doubles as the top subkey index when walking the schedule backwards.
    assign w_last_idx = r_short ? 4'd11 : 4'd15;
    assign w_last     = (r_k == w_last_idx);
    assign rnd_idx    = r_decrypt ? (w_last_idx - r_k) : r_k;

    assign f_din = r_r;
    assign f_km  = km;
    assign f_rot = kr;
    assign dout  = {r_r, r_l};

    always_comb begin
        unique case (rnd_idx)
            4'd0, 4'd3, 4'd6, 4'd9, 4'd12, 4'd15: f_type = 2'd1;
            4'd1, 4'd4, 4'd7, 4'd10, 4'd13:       f_type = 2'd2;
            default:                              f_type = 2'd3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        f_req        = 1'b0;
        dout_valid   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                f_req = 1'b1;
                if (f_ack && w_last) begin
                    w_state_next = S_OUT;
                end
            end
            S_OUT: begin
                dout_valid = 1'b1;
                if (dout_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_l       <= 32'd0;
            r_r       <= 32'd0;
            r_k       <= 4'd0;
            r_decrypt <= 1'b0;
            r_short   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_l       <= din[63:32];
                        r_r       <= din[31:0];
                        r_k       <= 4'd0;
                        r_decrypt <= decrypt;
                        r_short   <= short_key;
                    end
                end
                S_RUN: begin
                    // Feistel step; on the last round k wraps or overshoots, which is harmless in OUT.
                    if (f_ack) begin
                        r_l <= r_r;
                        r_r <= r_l ^ f_dout;
                        r_k <= r_k + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/cast5_round_ctrl.md
# cast5_round_ctrl

Iterative round sequencer for the CAST5 core. It owns the L/R half-block registers and walks 12 or 16 rounds over one shared round-function datapath: variable rotate, S-box lookup and type-1/2/3 combine. For each round it requests the subkey pair from the key schedule by index, presents R, Km, Kr and the round type to the datapath over a req/ack handshake, and folds the returned F value into L/R. It sits between the block-level load/unload handshake and the shared rotate/F datapath, and supports both encryption and decryption.

## Interface
Parameters: none. Round count is selected per block by `short_key`.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: load request. Accepted only when `start & ready`.
- `ready` out 1: high in IDLE only.
- `decrypt` in 1: 0 = encrypt, 1 = decrypt. Sampled when start is accepted.
- `short_key` in 1: 1 = 12 rounds (key ≤ 80 bits), 0 = 16 rounds. Sampled when start is accepted.
- `din` in 64: input block {L0, R0}. Sampled when start is accepted.
- `rnd_idx` out 4: subkey index presented to the key schedule.
- `km` in 32, `kr` in 5: masking key and rotate key for `rnd_idx`. Combinational return, same cycle.
- `f_req` out 1: round-function request.
- `f_ack` in 1: datapath result valid. Ignored unless `f_req` is high.
- `f_din` out 32: current R.
- `f_km` out 32: equals `km`.
- `f_rot` out 5: equals `kr`.
- `f_type` out 2: 1, 2 or 3.
- `f_dout` in 32: F result. Valid when `f_ack` is high.
- `dout` out 64: result {R_final, L_final}.
- `dout_valid` out 1, `dout_ready` in 1: output handshake.

## Operation
States: IDLE → RUN → OUT → IDLE.

- **IDLE**
  - `ready`=1.
  - On `start`: L<=din[63:32], R<=din[31:0].
  - Latch `decrypt` and `short_key`; N = 12 if `short_key`, else 16.
  - Round counter k<=0. Go to RUN.
- **RUN**
  - `f_req`=1 every cycle.
  - `rnd_idx` = k when encrypting, N-1-k when decrypting.
  - `f_type` = (rnd_idx mod 3)+1, i.e. indices 0,3,6,9,12,15→1; 1,4,7,10,13→2; 2,5,8,11,14→3.
  - On a cycle with `f_ack`=1: L<=R, R<=L^f_dout, k<=k+1.
  - If k==N-1 on that ack, go to OUT instead of staying in RUN.
  - If `f_ack`=0, hold all registers; `rnd_idx`, `f_din`, `f_km`, `f_rot` and `f_type` stay stable.
- **OUT**
  - `dout_valid`=1; `dout`={R, L}, which applies the CAST5 final swap.
  - `dout` is held stable until `dout_ready`=1.
  - On the handshake, go to IDLE.
- The mod-3 type is computed from the 4-bit index by a small decode, not a divider. The k counter is 4 bits; the compare is k==N-1 with N ∈ {12, 16}.
- Boundary behaviour:
  - `start` while not IDLE is ignored.
  - `start` in the same cycle as the OUT handshake is not accepted; it must be held until `ready`.
  - Changes to `decrypt`, `short_key` or `din` after acceptance have no effect.
- **Reset:** `rst` in any state forces IDLE next edge and aborts any in-flight block with no output. L, R and k clear to 0.
- Output values from the first cycle after reset:
  - `ready`=1.
  - `f_req`=0, `dout_valid`=0.
  - `dout`=0, `rnd_idx`=0, `f_din`=0, `f_type`=1.
  - Any `f_ack` arriving after reset is ignored.

## Timing
- Start accepted at cycle 0. The first request (`rnd_idx` 0 for encrypt, N-1 for decrypt) is presented in cycle 1.
- With `f_ack` tied high, round j completes in cycle j+1 and `dout_valid` rises in cycle N+1: 17 for 16 rounds, 13 for 12 rounds.
- Each cycle of `f_ack`=0 adds one cycle of latency.
- Throughput is one block per N+2 cycles minimum, counting the IDLE cycle between blocks.
- `f_req` deasserts in the cycle after the final ack. It never pulses low between rounds of the same block.
- All outputs are registered state or direct decodes of it. The only combinational paths from inputs are `f_km`=`km` and `f_rot`=`kr`.

## Test plan
- **Encrypt, 128-bit vector.** Reference key schedule 0123456712345678234567893456789A, `din`=0123456789ABCDEF, `f_ack`=1 → `dout`=238B4FE5847E44B2 with `dout_valid` at cycle 17. `rnd_idx` runs 0..15 and `f_type` runs 1,2,3,1,…,1.
- **Decrypt, same key.** `din`=238B4FE5847E44B2, `decrypt`=1 → `dout`=0123456789ABCDEF. `rnd_idx` runs 15..0 and `f_type` starts 1,3,2.
- **Short key.** `short_key`=1 → exactly 12 acks consumed and `dout_valid` at cycle 13. Encrypt indices 0..11; decrypt starts at 11. Result matches the behavioural model.
- **Backpressure.** Random `f_ack` (30% high) and `dout_ready` held low for 5 cycles → identical `dout`. Request signals and `dout` are stable while stalled; no extra or missing rounds.
- **Ignored start.** `start` pulsed during RUN and during OUT, including the handshake cycle → no effect. The next block is accepted only when `ready`=1.
- **Reset mid-run.** `rst` in round 7 → next cycle `ready`=1, `f_req`=0, `dout_valid`=0. A subsequent full block produces correct output.
